// File: rtl/updown_button_conditioner.sv
// Two-channel push-button conditioner: polarity normalisation, 2-FF synchronisation and
// counter-based debounce producing stable levels plus one-cycle press pulses.
module updown_button_conditioner #(
  parameter int unsigned DB_CYCLES  = 500000,
  parameter int unsigned CNT_W      = 20,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_u_raw,
  input  logic btn_d_raw,
  output logic u,
  output logic d,
  output logic u_rise,
  output logic d_rise
);

  typedef enum logic [1:0] {
    StIdle,
    StConfirmPress,
    StPressed,
    StConfirmRelease
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic [1:0] raw_pol;
  logic [1:0] sync1_q;
  logic [1:0] s_q;
  logic [1:0] level;
  logic [1:0] rise;

  // Channel 0 is up, channel 1 is down; internal signals are active-high.
  assign raw_pol = {btn_d_raw, btn_u_raw} ^ {2{ACTIVE_LOW}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= raw_pol;
      s_q     <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      case (state_q)
        StIdle: begin
          if (s_q[ch]) begin
            state_d = StConfirmPress;
            cnt_d   = '0;
          end
        end
        StConfirmPress: begin
          if (!s_q[ch]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StPressed;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StPressed: begin
          if (!s_q[ch]) begin
            state_d = StConfirmRelease;
            cnt_d   = '0;
          end
        end
        StConfirmRelease: begin
          if (s_q[ch]) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
      // Level registered from next state so it tracks the FSM with no extra cycle.
      level_d = (state_d == StPressed) || (state_d == StConfirmRelease);
    end

    assign level[ch] = level_q;
    assign rise[ch]  = rise_q;
  end

  assign u      = level[0];
  assign d      = level[1];
  assign u_rise = rise[0];
  assign d_rise = rise[1];

endmodule

// File: doc/updown_button_conditioner.md
# updown_button_conditioner

Two-channel input conditioner for the up/down counter's push buttons. It synchronizes the raw `btn_u_raw` and `btn_d_raw` pins into the `clk` domain, normalizes their polarity, and debounces each channel with its own counter-based state machine. It sits directly upstream of the counter control unit: the stable levels `u` and `d` drive that unit's `u`/`d` inputs. The control unit relies on these levels being glitch-free and released only after a confirmed release.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a press or a release (10 ms at 50 MHz). Legal range 2..2^CNT_W−1.
- `CNT_W`, default 20: width of each channel's debounce counter.
- `ACTIVE_LOW`, default 1: 1 means a raw pin at 0 is a press; 0 means a raw pin at 1 is a press.
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clock clk.
- `btn_u_raw`  in  1  raw up-button pin, asynchronous to clk.
- `btn_d_raw`  in  1  raw down-button pin, asynchronous to clk.
- `u`  out  1  debounced up level, 1 = pressed; feeds the control unit's `u`.
- `d`  out  1  debounced down level, 1 = pressed; feeds the control unit's `d`.
- `u_rise`  out  1  one-cycle pulse on each accepted up press.
- `d_rise`  out  1  one-cycle pulse on each accepted down press.

## Operation
- **Polarity.** Raw pins are XORed with `ACTIVE_LOW` before synchronization, so internal signals are active-high.
- **Synchronizer.** Each channel uses a 2-FF synchronizer. The second-stage output is `s`.
- **Reset.** Both synchronizer stages clear to 0 (not pressed). Both FSMs go to IDLE and counters clear to 0. All outputs are 0 while reset is high and during the first cycle after it.
- **Per-channel FSM.** Up and down are independent, identical instances. The counter is `cnt`.
  - IDLE: level 0. If s=1 → CONFIRM_PRESS with cnt←0; otherwise stay.
  - CONFIRM_PRESS: level 0.
    - s=0 → IDLE, cnt←0.
    - s=1 and cnt=DB_CYCLES−1 → PRESSED, cnt←0, rise pulse asserted.
    - Otherwise cnt←cnt+1.
  - PRESSED: level 1. If s=0 → CONFIRM_RELEASE with cnt←0; otherwise stay.
  - CONFIRM_RELEASE: level 1.
    - s=1 → PRESSED, cnt←0.
    - s=0 and cnt=DB_CYCLES−1 → IDLE, cnt←0.
    - Otherwise cnt←cnt+1.
  - Unreachable encodings → IDLE.
- **Outputs.** `u`/`d` are registered. Each is 1 exactly while its FSM is in PRESSED or CONFIRM_RELEASE.
- **Rise pulse.** `u_rise`/`d_rise` are registered and high for exactly one cycle: the first cycle the level is 1. There is no release pulse.
- **Counter.** It never exceeds DB_CYCLES−1 and never wraps. Any bounce restarts the confirmation from 0.
- **Simultaneous buttons.** Both channels may be asserted at once, including in the same cycle. No arbitration happens here; the control unit interprets u=d=1 as clear.
- **Reset mid-operation.** Outputs drop to 0 asynchronously. If a button is still held after reset deasserts, it must be confirmed again from IDLE and produces a fresh rise pulse.

## Timing
- **Press latency.** Raw press stable from before edge 0 gives `s`=1 after edge 2 and CONFIRM_PRESS after edge 3. The level rises and the rise pulse asserts after edge DB_CYCLES+3.
- **Release latency.** Release follows the same schedule: the level falls after edge DB_CYCLES+3.
- **Rejected glitches.** A pulse of at most DB_CYCLES synchronized cycles never changes the level. This holds in both directions, so a dropout during a hold does not release.
- **Minimum accepted press.** The raw signal must be stable for DB_CYCLES+1 consecutive synchronized samples, counting the IDLE→CONFIRM sample.
- **Channel independence.** Channel timing is fully independent; neither channel's state affects the other's latency.

## Test plan
All scenarios use DB_CYCLES=4 and ACTIVE_LOW=1; "press" means driving the raw pin to 0.
- **Reset values:** assert reset with both raw pins=0 (pressed) → u=d=u_rise=d_rise=0 throughout reset. After deassert, u rises exactly 7 edges later with a single 1-cycle u_rise.
- **Clean press and release:** hold btn_u_raw=0 for 20 cycles, then 1 → u=1 from edge 7 to 7 edges after release. u_rise is high for exactly 1 cycle. d stays 0.
- **Press glitch rejected:** btn_d_raw low for 3 cycles, then high → d and d_rise stay 0. FSM returns to IDLE.
- **Bouncy press:** toggle btn_u_raw 0/1/0/1/0 at 1-cycle spacing, then hold 0 → exactly one u_rise. u rises 7 edges after the final stable 0.
- **Release glitch rejected:** while u=1, pulse btn_u_raw high for 2 cycles → u stays 1 with no new u_rise.
- **Simultaneous presses, then mid-hold reset:** press both pins in the same cycle → u and d rise on the same edge with coincident rise pulses. Assert reset mid-hold → both drop immediately and re-qualify 7 edges after reset deasserts.
